pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage, superseding the single-width PC register. It produces an aligned fetch-group address with a lane mask. Redirect sources are prioritised: trap, then branch, then predictor. The block runs a valid/ready handshake with instruction memory and holds the PC under hazard stall.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_gen_if.sv | 24 ++
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and sizing helpers for the fetch-stage PC generator.
package pc_pkg;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {BOOT, RUN} state_t;

  typedef enum logic [2:0] {NONE, TRAP, BR, PRED, SEQ} src_t;

  function automatic int group_bytes(input int fetch_width);
    return 4 * fetch_width;
  endfunction

  // Bits of pc that select the starting lane inside a fetch group.
  function automatic int lane_off_w(input int fetch_width);
    return (fetch_width <= 1) ? 1 : $clog2(fetch_width);
  endfunction
endpackage

// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator (master) and instruction memory (slave).
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int FETCH_WIDTH = 1
);
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [XLEN-1:0]        pc_o;
  logic [FETCH_WIDTH-1:0] lane_mask_o;
  logic                   fetch_kill_o;
  logic                   misalign_o;

  modport master (
    output fetch_valid, pc_o, lane_mask_o, fetch_kill_o, misalign_o,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, pc_o, lane_mask_o, fetch_kill_o, misalign_o,
    output fetch_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-group PC generator: trap > branch > predictor > sequential, 1-cycle redirect latency.
// Holds pc while the request is not accepted or stalled; trap/branch redirects override both and kill.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FETCH_WIDTH  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            br_ctrl,
  input  logic [XLEN-1:0] br_addr,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_addr,
  input  logic            pc_stall,
  pc_gen_if.master        fetch
);
  localparam int GB = group_bytes(FETCH_WIDTH);

  state_t          state, state_nxt;
  src_t            src;
  logic [XLEN-1:0] pc, pc_nxt, seq, raw;
  logic            kill, kill_nxt, mis, mis_nxt, fire;

  assign seq = (pc & ~XLEN'(GB - 1)) + XLEN'(GB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      kill  <= 1'b0;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
      mis   <= mis_nxt;
    end
  end

  always_comb begin
    state_nxt = RUN;
    src       = NONE;
    raw       = pc;
    fire      = (state == RUN) && fetch.fetch_ready && !pc_stall;
    if (state == RUN) begin
      if (trap_valid) begin
        src = TRAP;
        raw = trap_addr;
      end else if (br_ctrl) begin
        src = BR;
        raw = br_addr;
      end else if (fire && pred_valid) begin
        src = PRED;
        raw = pred_addr;
      end else if (fire) begin
        src = SEQ;
        raw = seq;
      end
    end
    // pc and seq are already aligned, so forcing [1:0] only affects redirect targets.
    pc_nxt   = {raw[XLEN-1:2], 2'b00};
    kill_nxt = (src == TRAP) || (src == BR);
    mis_nxt  = ((src == TRAP) || (src == BR) || (src == PRED)) && (raw[1:0] != 2'b00);
  end

  assign fetch.fetch_valid  = (state == RUN);
  assign fetch.pc_o         = pc;
  assign fetch.fetch_kill_o = kill;
  assign fetch.misalign_o   = mis;

  generate
    if (FETCH_WIDTH == 1) begin : g_single
      assign fetch.lane_mask_o = 1'b1;
    end else begin : g_multi
      localparam int OW = lane_off_w(FETCH_WIDTH);
      logic [OW-1:0]          off;
      logic [FETCH_WIDTH-1:0] mask;
      assign off = pc[OW+1:2];
      always_comb begin
        mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) mask[i] = (i >= int'(off));
      end
      assign fetch.lane_mask_o = mask;
    end
  endgenerate
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench: FETCH_WIDTH=1 (reset vector 0x100) and FETCH_WIDTH=4 (reset vector 0) instances.
module tb_pc_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a = 1'b1, trap_a = 1'b0, br_a = 1'b0, pred_a = 1'b0, stall_a = 1'b0;
  logic [31:0] trap_addr_a = '0, br_addr_a = '0, pred_addr_a = '0;
  logic        rst_b = 1'b1, trap_b = 1'b0, br_b = 1'b0, pred_b = 1'b0, stall_b = 1'b0;
  logic [31:0] trap_addr_b = '0, br_addr_b = '0, pred_addr_b = '0;

  pc_gen_if #(.XLEN(32), .FETCH_WIDTH(1)) ifa ();
  pc_gen_if #(.XLEN(32), .FETCH_WIDTH(4)) ifb ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .FETCH_WIDTH(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .trap_valid(trap_a), .trap_addr(trap_addr_a),
    .br_ctrl(br_a), .br_addr(br_addr_a),
    .pred_valid(pred_a), .pred_addr(pred_addr_a),
    .pc_stall(stall_a), .fetch(ifa.master)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .FETCH_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .trap_valid(trap_b), .trap_addr(trap_addr_b),
    .br_ctrl(br_b), .br_addr(br_addr_b),
    .pred_valid(pred_b), .pred_addr(pred_addr_b),
    .pc_stall(stall_b), .fetch(ifb.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] pc, input logic vld,
                         input logic kill, input logic mis);
    check_eq({tag, "_pc"}, ifa.pc_o, pc);
    check_eq({tag, "_vld"}, 32'(ifa.fetch_valid), 32'(vld));
    check_eq({tag, "_kill"}, 32'(ifa.fetch_kill_o), 32'(kill));
    check_eq({tag, "_mis"}, 32'(ifa.misalign_o), 32'(mis));
  endtask

  initial begin
    ifa.fetch_ready = 1'b1;
    ifb.fetch_ready = 1'b0;

    // ---------------- FETCH_WIDTH=1, RESET_VECTOR=0x100 ----------------
    tick(); tick();
    check_a("a_reset", 32'h100, 1'b0, 1'b0, 1'b0);
    check_eq("a_reset_mask", 32'(ifa.lane_mask_o), 32'h1);

    rst_a = 1'b0;
    tick();
    check_a("a_first", 32'h100, 1'b1, 1'b0, 1'b0);
    tick();
    check_a("a_seq1", 32'h104, 1'b1, 1'b0, 1'b0);
    tick();
    check_a("a_seq2", 32'h108, 1'b1, 1'b0, 1'b0);

    ifa.fetch_ready = 1'b0;
    stall_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a("a_hold", 32'h108, 1'b1, 1'b0, 1'b0);
    end

    br_a = 1'b1; br_addr_a = 32'h40;
    tick();
    check_a("a_br_stalled", 32'h40, 1'b1, 1'b1, 1'b0);
    br_a = 1'b0;
    tick();
    check_a("a_br_after", 32'h40, 1'b1, 1'b0, 1'b0);

    ifa.fetch_ready = 1'b1;
    stall_a = 1'b0;
    trap_a = 1'b1; trap_addr_a = 32'h80;
    br_a = 1'b1;   br_addr_a = 32'h40;
    pred_a = 1'b1; pred_addr_a = 32'h20;
    tick();
    check_a("a_prio", 32'h80, 1'b1, 1'b1, 1'b0);
    trap_a = 1'b0; br_a = 1'b0; pred_a = 1'b0;
    tick();
    check_a("a_prio_next", 32'h84, 1'b1, 1'b0, 1'b0);

    br_a = 1'b1; br_addr_a = 32'h43;
    tick();
    check_a("a_misal", 32'h40, 1'b1, 1'b1, 1'b1);
    br_a = 1'b0;
    tick();
    check_a("a_misal_end", 32'h44, 1'b1, 1'b0, 1'b0);

    ifa.fetch_ready = 1'b0;
    pred_a = 1'b1; pred_addr_a = 32'h203;
    tick();
    check_a("a_pred_nofire", 32'h44, 1'b1, 1'b0, 1'b0);
    ifa.fetch_ready = 1'b1;
    tick();
    check_a("a_pred_fire", 32'h200, 1'b1, 1'b0, 1'b1);
    pred_a = 1'b0;

    br_a = 1'b1; br_addr_a = 32'hFFFF_FFFC;
    tick();
    check_a("a_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    br_a = 1'b0;
    tick();
    check_a("a_wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    ifa.fetch_ready = 1'b0;
    rst_a = 1'b1;
    br_a = 1'b1; br_addr_a = 32'h40;
    tick();
    check_a("a_rst_mid", 32'h100, 1'b0, 1'b0, 1'b0);
    rst_a = 1'b0;
    tick();
    check_a("a_boot_ignore", 32'h100, 1'b1, 1'b0, 1'b0);
    br_a = 1'b0;

    // ---------------- FETCH_WIDTH=4, RESET_VECTOR=0 ----------------
    tick();
    check_eq("b_reset_pc", ifb.pc_o, 32'h0);
    check_eq("b_reset_mask", 32'(ifb.lane_mask_o), 32'hF);
    check_eq("b_reset_vld", 32'(ifb.fetch_valid), 32'h0);
    rst_b = 1'b0;
    tick();
    check_eq("b_run_vld", 32'(ifb.fetch_valid), 32'h1);

    br_b = 1'b1; br_addr_b = 32'h208;
    tick();
    check_eq("b_br_pc", ifb.pc_o, 32'h208);
    check_eq("b_br_mask", 32'(ifb.lane_mask_o), 32'hC);
    check_eq("b_br_kill", 32'(ifb.fetch_kill_o), 32'h1);
    br_b = 1'b0;
    ifb.fetch_ready = 1'b1;
    tick();
    check_eq("b_seq_pc", ifb.pc_o, 32'h210);
    check_eq("b_seq_mask", 32'(ifb.lane_mask_o), 32'hF);
    check_eq("b_seq_kill", 32'(ifb.fetch_kill_o), 32'h0);

    trap_b = 1'b1; trap_addr_b = 32'h31E;
    tick();
    check_eq("b_trap_pc", ifb.pc_o, 32'h31C);
    check_eq("b_trap_mask", 32'(ifb.lane_mask_o), 32'h8);
    check_eq("b_trap_mis", 32'(ifb.misalign_o), 32'h1);
    trap_b = 1'b0;
    tick();
    check_eq("b_trap_seq", ifb.pc_o, 32'h320);
    check_eq("b_trap_mis_end", 32'(ifb.misalign_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
